// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller beside ID and EX: load-use bubbles, HI/LO occupancy
// by multi-cycle mult/div, taken-branch squashes, and a stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs_From_IF_ID,
    input  logic [4:0]  Rt_From_IF_ID,
    input  logic [1:0]  RegRead,
    input  logic        HiLo_Use_ID,
    input  logic [4:0]  Rt_From_ID_EX,
    input  logic        MemRead_From_ID_EX,
    input  logic [3:0]  RegWrite_From_ID_EX,
    input  logic        MulDiv_Start_EX,
    input  logic        MulDiv_IsDiv_EX,
    input  logic        Branch_Taken_EX,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        MulDiv_Busy,
    output logic        MulDiv_Done,
    output logic [15:0] Stall_Count
);

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   md_cnt_q, md_cnt_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;

    logic               lu_haz;
    logic               md_haz;
    logic               stall;
    logic               md_busy;
    logic               src_match;

    assign md_busy = (md_cnt_q != '0);

    always_comb begin
        src_match = (RegRead[0] && (Rs_From_IF_ID == Rt_From_ID_EX)) ||
                    (RegRead[1] && (Rt_From_IF_ID == Rt_From_ID_EX));
        lu_haz    = (state_q == RUN) && MemRead_From_ID_EX &&
                    (RegWrite_From_ID_EX != 4'd0) && (Rt_From_ID_EX != 5'd0) &&
                    src_match;
        md_haz    = HiLo_Use_ID && md_busy;
        // A taken branch squashes the dependent instruction, so it never stalls.
        stall     = (lu_haz || md_haz) && !Branch_Taken_EX;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (lu_haz && !Branch_Taken_EX) state_d = LU_STALL;
            LU_STALL: state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        // A start while busy cannot legally occur and must not reload the count.
        if (MulDiv_Start_EX && !md_busy) begin
            md_cnt_d = MulDiv_IsDiv_EX ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_comb begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
        MulDiv_Busy = 1'b0;
        MulDiv_Done = 1'b0;
        if (!reset) begin
            PC_Write    = !stall;
            IF_ID_Write = !stall;
            IF_ID_Flush = Branch_Taken_EX;
            ID_EX_Flush = stall || Branch_Taken_EX;
            MulDiv_Busy = md_busy;
            MulDiv_Done = (md_cnt_q == CNT_W'(1));
        end
    end

    assign Stall_Count = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller that sits beside the ID and EX stages, next to the forwarding unit.
- Covers the cases forwarding cannot hide: load-use hazards, multi-cycle mult/div occupancy of HI/LO, and taken-branch squashes.
- Drives PC/IF_ID write enables and IF_ID/ID_EX flushes, and tracks mult/div busy time with an internal counter.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 4, HI/LO busy cycles after a mult/multu leaves EX.
- DIV_CYCLES, 32, HI/LO busy cycles after a div/divu leaves EX.
- CNT_W, 6, mult/div counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  single pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Rs_From_IF_ID  input  5  rs field of instruction in ID.
- Rt_From_IF_ID  input  5  rt field of instruction in ID.
- RegRead  input  2  bit0: ID reads rs; bit1: ID reads rt.
- HiLo_Use_ID  input  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div.
- Rt_From_ID_EX  input  5  destination of load in EX.
- MemRead_From_ID_EX  input  1  EX instruction is a load.
- RegWrite_From_ID_EX  input  4  byte write enables of EX instruction; nonzero means it writes.
- MulDiv_Start_EX  input  1  valid mult/div in EX this cycle.
- MulDiv_IsDiv_EX  input  1  1 = div/divu, 0 = mult/multu; sampled with Start.
- Branch_Taken_EX  input  1  branch/jump in EX resolved taken.
- PC_Write  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register enable.
- IF_ID_Flush  output  1  clear IF/ID to nop.
- ID_EX_Flush  output  1  load bubble into ID/EX.
- MulDiv_Busy  output  1  HI/LO result not yet available.
- MulDiv_Done  output  1  one-cycle pulse when result becomes available.
- Stall_Count  output  16  saturating count of stall cycles.

Behaviour:
- State: FSM {RUN, LU_STALL}, counter md_cnt[CNT_W-1:0], Stall_Count.

Reset (reset high at edge):
- FSM goes to RUN; md_cnt and Stall_Count go to 0.
- While reset is high, outputs are: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, MulDiv_Busy=0, MulDiv_Done=0.
- Reset mid mult/div aborts it; no Done pulse is issued.

Hazard conditions (combinational):
- lu_haz = (state==RUN) & MemRead_From_ID_EX & (RegWrite_From_ID_EX!=0) & (Rt_From_ID_EX!=0) & ((RegRead[0] & Rs_From_IF_ID==Rt_From_ID_EX) | (RegRead[1] & Rt_From_IF_ID==Rt_From_ID_EX)).
- md_haz = HiLo_Use_ID & MulDiv_Busy.
- stall = (lu_haz | md_haz) & ~Branch_Taken_EX.

Outputs (reset low):
- PC_Write = ~stall. A taken branch writes the target, so PC_Write=1.
- IF_ID_Write = ~stall.
- IF_ID_Flush = Branch_Taken_EX.
- ID_EX_Flush = stall | Branch_Taken_EX.

FSM:
- RUN -> LU_STALL when lu_haz & ~Branch_Taken_EX.
- LU_STALL -> RUN unconditionally next cycle.
- Load-use stall is therefore exactly 1 cycle. After it the load is in WB and the forwarding unit's MEM_WB path supplies the data.
- lu_haz is suppressed in LU_STALL, so back-to-back load-use stalls cannot double-count.

Mult/div counter:
- On edge with MulDiv_Start_EX=1 and md_cnt==0: md_cnt <= DIV_CYCLES if IsDiv, else MULT_CYCLES.
- Otherwise, if md_cnt!=0: md_cnt <= md_cnt-1.
- MulDiv_Busy = (md_cnt!=0), registered-state derived.
- MulDiv_Done = (md_cnt==1); high for exactly one cycle, the last busy cycle.
- Result is usable the cycle after Done.
- Start while md_cnt!=0 is illegal (md_haz prevents it). It is ignored and the counter is not reloaded.
- Branch_Taken_EX does not cancel a mult/div already in EX; the counter keeps running.

Stall_Count:
- Increments on each edge where stall=1.
- Saturates at 16'hFFFF.

Simultaneous events:
- Branch_Taken_EX wins over lu_haz/md_haz: flush both, no stall, FSM stays RUN, Stall_Count unchanged.
- lu_haz and md_haz together count as one stall cycle.

Test Plan:
- Load-use: load r5 in EX (MemRead=1, RegWrite=4'hF, Rt_ID_EX=5), ID add with Rs=5, RegRead=01 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, then next cycle all 1/1/0; Stall_Count=1.
- Zero register / no read: same load with Rt_ID_EX=0, or RegRead=00 -> no stall, Stall_Count stays 0.
- Mult then mfhi: Start_EX=1, IsDiv=0, then HiLo_Use_ID=1 -> Busy for 4 cycles, stall for 4 cycles, Done high in the 4th, PC_Write=1 on the 5th; Stall_Count=4.
- Div with branch: Start_EX=1, IsDiv=1; at busy cycle 10 assert Branch_Taken_EX with HiLo_Use_ID=1 -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1 that cycle; Busy continues; Done occurs at cycle 32.
- Reset mid-div at busy cycle 5 -> next cycle Busy=0, no Done, Stall_Count=0, outputs at reset values while reset is high.
- Saturation: hold md_haz for 70000 cycles by repeated mult + HiLo use -> Stall_Count sticks at 16'hFFFF.
